// File: rtl/mtr_drv.sv
// Dual half-bridge PWM driver: shared 12-bit period counter, per-side duty
// latch, raw compare and dead-time insertion with registered gate outputs.
module mtr_drv #(
  parameter logic [5:0] DEAD_TIME = 6'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        en,
  output logic        lft_PWM1,
  output logic        lft_PWM2,
  output logic        rght_PWM1,
  output logic        rght_PWM2,
  output logic        PWM_synch
);

  localparam int unsigned CNT_W  = 12;
  localparam int unsigned DEAD_W = 6;
  localparam int unsigned NSIDE  = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DUTY_MID = {1'b1, {(CNT_W-1){1'b0}}};

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              synch_q, synch_d;
  logic [CNT_W-1:0]  spd    [NSIDE];
  logic [CNT_W-1:0]  duty_q [NSIDE];
  logic [CNT_W-1:0]  duty_d [NSIDE];
  logic [DEAD_W-1:0] dead_q [NSIDE];
  logic [DEAD_W-1:0] dead_d [NSIDE];
  logic [NSIDE-1:0]  raw_q, raw_d;
  logic [NSIDE-1:0]  pwm1_q, pwm1_d;
  logic [NSIDE-1:0]  pwm2_q, pwm2_d;

  // Index 0 is the left bridge, index 1 the right bridge.
  assign spd[0] = lft_spd;
  assign spd[1] = rght_spd;

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    synch_d = (cnt_q == CNT_LAST);
    raw_d   = '0;
    pwm1_d  = '0;
    pwm2_d  = '0;
    for (int s = 0; s < NSIDE; s++) begin
      duty_d[s] = duty_q[s];
      dead_d[s] = dead_q[s];
      // Signed command to offset-binary duty, loaded only at the period boundary.
      if (cnt_q == CNT_LAST) begin
        duty_d[s] = spd[s] ^ DUTY_MID;
      end
      raw_d[s] = (cnt_q < duty_q[s]);
      // Any raw edge or disable restarts the dead window with both gates off.
      if (!en || (raw_d[s] != raw_q[s])) begin
        dead_d[s] = DEAD_TIME;
      end else if (dead_q[s] != '0) begin
        dead_d[s] = dead_q[s] - DEAD_W'(1);
      end else begin
        pwm1_d[s] = raw_q[s];
        pwm2_d[s] = ~raw_q[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      synch_q <= 1'b0;
      raw_q   <= '0;
      pwm1_q  <= '0;
      pwm2_q  <= '0;
      for (int s = 0; s < NSIDE; s++) begin
        duty_q[s] <= DUTY_MID;
        dead_q[s] <= DEAD_TIME;
      end
    end else begin
      cnt_q   <= cnt_d;
      synch_q <= synch_d;
      raw_q   <= raw_d;
      pwm1_q  <= pwm1_d;
      pwm2_q  <= pwm2_d;
      for (int s = 0; s < NSIDE; s++) begin
        duty_q[s] <= duty_d[s];
        dead_q[s] <= dead_d[s];
      end
    end
  end

  assign lft_PWM1  = pwm1_q[0];
  assign lft_PWM2  = pwm2_q[0];
  assign rght_PWM1 = pwm1_q[1];
  assign rght_PWM2 = pwm2_q[1];
  assign PWM_synch = synch_q;

endmodule

// File: tb/tb_mtr_drv.sv
// Directed bench for mtr_drv: per-period gate high-time vectors plus
// hand-written reset, latch-latency, enable-gating and mid-period reset sequences.
module tb_mtr_drv;

  typedef struct {
    logic [11:0] lspd;
    logic [11:0] rspd;
    int          l1;
    int          l2;
    int          r1;
    int          r2;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic        lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch;

  int   n_err = 0;
  int   n_chk = 0;
  int   viol = 0;
  int   synch_bad = 0;
  logic mon_en = 1'b0;
  logic [11:0] tb_cnt;
  logic        tb_after_rst;

  vec_t vecs [4];
  int   l1, l2, r1, r2, sy, n, bad;

  always #5 clk = ~clk;

  mtr_drv #(.DEAD_TIME(6'h20)) dut (
    .clk       (clk),
    .rst       (rst),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .en        (en),
    .lft_PWM1  (lft_PWM1),
    .lft_PWM2  (lft_PWM2),
    .rght_PWM1 (rght_PWM1),
    .rght_PWM2 (rght_PWM2),
    .PWM_synch (PWM_synch)
  );

  // Reference period counter and reset-edge tracker.
  always @(posedge clk) begin
    if (rst) tb_cnt <= 12'h000;
    else     tb_cnt <= tb_cnt + 12'd1;
    tb_after_rst <= rst;
  end

  // Gate interlock and period-marker monitors.
  always @(negedge clk) begin
    if (mon_en) begin
      if ((lft_PWM1 === 1'b1 && lft_PWM2 === 1'b1) ||
          (rght_PWM1 === 1'b1 && rght_PWM2 === 1'b1)) viol++;
      if (PWM_synch !== ((tb_cnt == 12'h000) && !tb_after_rst)) synch_bad++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_synch(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (PWM_synch !== 1'b1 && k < 4200);
    if (PWM_synch !== 1'b1) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: no PWM_synch after %0d cycles, got 0 expected 1", tag, k);
    end
  endtask

  task automatic wait_cnt(input logic [11:0] target, input string tag);
    int k;
    k = 0;
    while (tb_cnt !== target && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (tb_cnt !== target) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: counter never reached %0h, got %0h expected %0h", tag, target, tb_cnt, target);
    end
  endtask

  initial begin
    vecs[0] = '{12'h000, 12'h000, 2015, 2015, 2015, 2015};
    vecs[1] = '{12'h7FF, 12'h800, 4062,    0,    0, 4096};
    vecs[2] = '{12'h400, 12'hC00, 3039,  991,  991, 3039};
    vecs[3] = '{12'h801, 12'h7FE,    0, 4062, 4061,    0};

    // Reset overrides en; duty starts at mid-scale regardless of commands.
    rst = 1'b1; en = 1'b1; lft_spd = 12'h7FF; rght_spd = 12'h7FF;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    check("rst_lft_PWM1", lft_PWM1, 0);
    check("rst_lft_PWM2", lft_PWM2, 0);
    check("rst_rght_PWM1", rght_PWM1, 0);
    check("rst_rght_PWM2", rght_PWM2, 0);
    check("rst_PWM_synch", PWM_synch, 0);
    rst = 1'b0;
    n = 0;
    while (PWM_synch !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
      if (n == 'h100) check("rst_duty_lft_PWM1_early", lft_PWM1, 1);
      if (n == 'h900) begin
        check("rst_duty_lft_PWM2_late", lft_PWM2, 1);
        check("rst_duty_rght_PWM2_late", rght_PWM2, 1);
      end
    end
    check("rst_first_synch_cycles", n, 4096);

    // Steady-state high time per 4096-cycle period.
    for (int i = 0; i < 4; i++) begin
      lft_spd = vecs[i].lspd;
      rght_spd = vecs[i].rspd;
      wait_synch("vec_settle");
      wait_synch("vec_settle");
      l1 = 0; l2 = 0; r1 = 0; r2 = 0; sy = 0;
      for (int k = 0; k < 4096; k++) begin
        if (lft_PWM1 === 1'b1) l1++;
        if (lft_PWM2 === 1'b1) l2++;
        if (rght_PWM1 === 1'b1) r1++;
        if (rght_PWM2 === 1'b1) r2++;
        if (PWM_synch === 1'b1) sy++;
        @(negedge clk);
      end
      check($sformatf("v%0d_lft_PWM1_hi", i), l1, vecs[i].l1);
      check($sformatf("v%0d_lft_PWM2_hi", i), l2, vecs[i].l2);
      check($sformatf("v%0d_rght_PWM1_hi", i), r1, vecs[i].r1);
      check($sformatf("v%0d_rght_PWM2_hi", i), r2, vecs[i].r2);
      check($sformatf("v%0d_synch_per_period", i), sy, 1);
    end

    // Mid-period command change holds until the boundary, then 2-clock latency plus dead time.
    lft_spd = 12'h800; rght_spd = 12'h000;
    wait_synch("midchg_settle");
    wait_synch("midchg_settle");
    wait_cnt(12'h100, "midchg_cnt");
    lft_spd = 12'h7FF;
    bad = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (PWM_synch !== 1'b1 && !(lft_PWM2 === 1'b1 && lft_PWM1 === 1'b0)) bad++;
    end while (PWM_synch !== 1'b1 && n < 5000);
    check("midchg_period_hold_bad_cycles", bad, 0);
    check("latch_edge_lft_PWM2", lft_PWM2, 1);
    @(negedge clk);
    check("latch_p1_lft_PWM2", lft_PWM2, 0);
    check("latch_p1_lft_PWM1", lft_PWM1, 0);
    repeat (32) @(negedge clk);
    check("latch_cnt33_lft_PWM1", lft_PWM1, 0);
    @(negedge clk);
    check("latch_cnt34_lft_PWM1", lft_PWM1, 1);

    // Enable gating and re-enable dead time.
    wait_cnt(12'h200, "en_cnt");
    en = 1'b0;
    @(negedge clk);
    check("en_off_lft_PWM1", lft_PWM1, 0);
    check("en_off_lft_PWM2", lft_PWM2, 0);
    check("en_off_rght_PWM1", rght_PWM1, 0);
    check("en_off_rght_PWM2", rght_PWM2, 0);
    repeat (4) @(negedge clk);
    en = 1'b1;
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (lft_PWM1 !== 1'b0 || lft_PWM2 !== 1'b0 || rght_PWM1 !== 1'b0 || rght_PWM2 !== 1'b0) bad++;
    end
    check("en_reenable_quiet_bad_cycles", bad, 0);
    @(negedge clk);
    check("en_resume_lft_PWM1", lft_PWM1, 1);
    check("en_resume_rght_PWM1", rght_PWM1, 1);

    // Reset pulse mid-period while gates are driving.
    wait_cnt(12'h9A3, "midrst_cnt");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_lft_PWM1", lft_PWM1, 0);
    check("midrst_lft_PWM2", lft_PWM2, 0);
    check("midrst_rght_PWM1", rght_PWM1, 0);
    check("midrst_rght_PWM2", rght_PWM2, 0);
    check("midrst_PWM_synch", PWM_synch, 0);
    n = 0;
    while (PWM_synch !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("midrst_first_synch_cycles", n, 4096);

    check("interlock_violations", viol, 0);
    check("synch_marker_mismatches", synch_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mtr_drv.md
MTR_DRV -- requirements
Module: mtr_drv

Interface
REQ-001 Parameter DEAD_TIME, default 6'h20: number of clocks both gate drives of a half-bridge are held low around each switching edge.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 lft_spd  input  12  signed left motor speed command, range -2048..+2047.
REQ-005 rght_spd  input  12  signed right motor speed command, same format as lft_spd.
REQ-006 en  input  1  driver enable; low forces all gate outputs low.
REQ-007 lft_PWM1  output  1  left high-side gate drive.
REQ-008 lft_PWM2  output  1  left low-side gate drive.
REQ-009 rght_PWM1  output  1  right high-side gate drive.
REQ-010 rght_PWM2  output  1  right low-side gate drive.
REQ-011 PWM_synch  output  1  period marker; high in exactly the cycles where cnt==12'h000.

Function
REQ-012 cnt SHALL be a shared 12-bit free-running up-counter: +1 every clock, wraps 12'hFFF -> 12'h000, period 4096 clocks.
REQ-013 Duty latch: each side's 12-bit unsigned duty SHALL load spd + 12'h800 (MSB inverted) only on the edge where cnt==12'hFFF, so commands take effect at the next cnt==0 and never mid-period.
REQ-014 Duty mapping: -2048 -> duty 0; 0 -> duty 12'h800 (50%, zero torque); +2047 -> duty 12'hFFF.
REQ-015 Raw compare, per side, every clock: raw_q <= (cnt < duty), unsigned compare.
REQ-016 Dead-time, per side, one 6-bit dead_cnt, priority order:
- (a) en low: dead_cnt <= DEAD_TIME, both outputs <= 0.
- (b) else if the new raw_q value differs from the current raw_q: dead_cnt <= DEAD_TIME, both outputs <= 0.
- (c) else if dead_cnt != 0: dead_cnt decrements, both outputs <= 0.
- (d) else: PWM1 <= raw_q, PWM2 <= ~raw_q.
REQ-017 Outputs SHALL be registered; PWM1 and PWM2 of one side SHALL never be high in the same cycle under any input sequence.
REQ-018 After each raw transition, both outputs of that side SHALL be low for exactly DEAD_TIME+1 clocks.
REQ-019 A transition occurring while dead_cnt != 0 SHALL restart dead_cnt at DEAD_TIME; pulses shorter than the dead time are suppressed.
REQ-020 Latency, absent dead time: duty change visible at the outputs 2 clocks after the cnt==12'hFFF latch edge.
REQ-021 Boundary, duty 0: raw is never high, so PWM1 stays low and PWM2 stays high continuously.
REQ-022 Boundary, duty 12'hFFF: raw is low only at cnt==12'hFFF; both outputs are low DEAD_TIME+2 clocks per period and PWM2 is never high.
REQ-023 The counter SHALL run regardless of en; deasserting en SHALL drive outputs low at the next edge.
REQ-024 On re-enable, the first high output SHALL appear at the (DEAD_TIME+1)th rising edge with en=1.
REQ-025 Left and right paths SHALL be independent except for the shared cnt and PWM_synch.

Reset
REQ-026 Reset values on the first rising edge with rst=1: cnt=0, both duties=12'h800, raw_q=0, dead_cnt=DEAD_TIME, all PWM outputs 0, PWM_synch 0.
REQ-027 Reset SHALL override en and any in-progress dead time, and SHALL take effect on the next edge mid-period.
REQ-028 After rst falls, cnt SHALL increment from 0 and the first PWM_synch pulse SHALL occur when cnt next returns to 0.

Verification
REQ-029 Zero speed: DEAD_TIME=32, lft_spd=rght_spd=0, en=1, steady state -> per 4096-clock period each PWM1 high 2015 clocks, each PWM2 high 2015 clocks, both low 66 clocks.
REQ-030 Full forward: lft_spd=12'h7FF -> lft_PWM1 high 4062 clocks per period, lft_PWM2 never high.
REQ-031 Full reverse: rght_spd=12'h800 -> rght_PWM1 never high; rght_PWM2 continuously high after its initial dead time.
REQ-032 Mid-period command change: lft_spd 0 -> 12'h400 at cnt=12'h100 -> current period unchanged; from the next PWM_synch, raw is high 3072 clocks per period.
REQ-033 Enable gating: en low during PWM1 high -> all outputs 0 next cycle; en high again -> outputs stay 0 for 32 edges, then resume.
REQ-034 Mid-operation reset and interlock: rst pulsed at cnt=12'h9A3 -> reset values next edge; the assertion that PWM1&PWM2 is never high on either side holds throughout all scenarios.
